conv3x3_engine: RTL and testbench

CONV3X3_ENGINE -- requirements
Module: conv3x3_engine

---
 rtl/conv3x3_engine.sv | 135 +++++++++++++
 tb/tb_conv3x3_engine.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/conv3x3_engine.sv
// 3x3 valid convolution of a latched 4x4 matrix, one MAC per cycle.
// The 2x2 saturated result is published on c11..c22 with a one-cycle done pulse.
module conv3x3_engine #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              active_store,
  input  logic [DATA_W-1:0] a11, a12, a13, a14,
  input  logic [DATA_W-1:0] a21, a22, a23, a24,
  input  logic [DATA_W-1:0] a31, a32, a33, a34,
  input  logic [DATA_W-1:0] a41, a42, a43, a44,
  input  logic [COEF_W-1:0] b11, b12, b13,
  input  logic [COEF_W-1:0] b21, b22, b23,
  input  logic [COEF_W-1:0] b31, b32, b33,
  output logic [DATA_W-1:0] c11, c12, c21, c22,
  output logic              done,
  output logic              busy
);

  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = PROD_W + 4;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0] a_q [16];
  logic [COEF_W-1:0] b_q [9];
  logic [DATA_W-1:0] res_q [4];
  logic [ACC_W-1:0]  acc_q;
  logic [3:0]        k_q;
  logic [1:0]        o_q;

  logic [1:0]        i_c, j_c, row_c, col_c;
  logic [3:0]        a_idx;
  logic [PROD_W-1:0] prod_c;
  logic [ACC_W-1:0]  sum_c;
  logic              last_mac;
  logic              start;

  function automatic logic [DATA_W-1:0] sat_u(input logic [ACC_W-1:0] v);
    return (|v[ACC_W-1:DATA_W]) ? '1 : v[DATA_W-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  assign start    = (state_q == IDLE) && active_store;
  assign last_mac = (k_q == 4'd8);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (active_store) state_d = CALC;
      CALC: if (last_mac && o_q == 2'd3) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign done = (state_q == DONE);
  assign busy = (state_q != IDLE);

  // Kernel tap (i,j) from k, row-major; output window origin (r,s) from o.
  always_comb begin
    i_c = 2'd0;
    j_c = 2'd0;
    case (k_q)
      4'd0: begin i_c = 2'd0; j_c = 2'd0; end
      4'd1: begin i_c = 2'd0; j_c = 2'd1; end
      4'd2: begin i_c = 2'd0; j_c = 2'd2; end
      4'd3: begin i_c = 2'd1; j_c = 2'd0; end
      4'd4: begin i_c = 2'd1; j_c = 2'd1; end
      4'd5: begin i_c = 2'd1; j_c = 2'd2; end
      4'd6: begin i_c = 2'd2; j_c = 2'd0; end
      4'd7: begin i_c = 2'd2; j_c = 2'd1; end
      4'd8: begin i_c = 2'd2; j_c = 2'd2; end
      default: begin i_c = 2'd0; j_c = 2'd0; end
    endcase
  end

  assign row_c  = i_c + {1'b0, o_q[1]};
  assign col_c  = j_c + {1'b0, o_q[0]};
  assign a_idx  = {row_c, col_c};
  assign prod_c = PROD_W'(a_q[a_idx]) * PROD_W'(b_q[k_q]);
  assign sum_c  = acc_q + ACC_W'(prod_c);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int n = 0; n < 16; n++) a_q[n] <= '0;
      for (int n = 0; n < 9; n++)  b_q[n] <= '0;
      for (int n = 0; n < 4; n++)  res_q[n] <= '0;
      acc_q <= '0;
      k_q   <= '0;
      o_q   <= '0;
      c11   <= '0;
      c12   <= '0;
      c21   <= '0;
      c22   <= '0;
    end else if (start) begin
      a_q[0]  <= a11; a_q[1]  <= a12; a_q[2]  <= a13; a_q[3]  <= a14;
      a_q[4]  <= a21; a_q[5]  <= a22; a_q[6]  <= a23; a_q[7]  <= a24;
      a_q[8]  <= a31; a_q[9]  <= a32; a_q[10] <= a33; a_q[11] <= a34;
      a_q[12] <= a41; a_q[13] <= a42; a_q[14] <= a43; a_q[15] <= a44;
      b_q[0]  <= b11; b_q[1]  <= b12; b_q[2]  <= b13;
      b_q[3]  <= b21; b_q[4]  <= b22; b_q[5]  <= b23;
      b_q[6]  <= b31; b_q[7]  <= b32; b_q[8]  <= b33;
      acc_q   <= '0;
      k_q     <= '0;
      o_q     <= '0;
    end else if (state_q == CALC) begin
      if (last_mac) begin
        res_q[o_q] <= sat_u(sum_c);
        acc_q      <= '0;
        k_q        <= '0;
        o_q        <= o_q + 2'd1;
        // The last window lands in the same edge it is copied out, so bypass res_q[3].
        if (o_q == 2'd3) begin
          c11 <= res_q[0];
          c12 <= res_q[1];
          c21 <= res_q[2];
          c22 <= sat_u(sum_c);
        end
      end else begin
        acc_q <= sum_c;
        k_q   <= k_q + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_conv3x3_engine.sv
// Directed bench for conv3x3_engine: hand-computed results, latency, busy/done
// framing, operand isolation, reset abort and back-to-back starts.
module tb_conv3x3_engine;

  logic       clk = 1'b0;
  logic       reset;
  logic       active_store;
  logic [7:0] a_v [16];
  logic [7:0] b_v [9];
  logic [7:0] c11, c12, c21, c22;
  logic       done, busy;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  conv3x3_engine dut (
    .clk(clk), .reset(reset), .active_store(active_store),
    .a11(a_v[0]),  .a12(a_v[1]),  .a13(a_v[2]),  .a14(a_v[3]),
    .a21(a_v[4]),  .a22(a_v[5]),  .a23(a_v[6]),  .a24(a_v[7]),
    .a31(a_v[8]),  .a32(a_v[9]),  .a33(a_v[10]), .a34(a_v[11]),
    .a41(a_v[12]), .a42(a_v[13]), .a43(a_v[14]), .a44(a_v[15]),
    .b11(b_v[0]), .b12(b_v[1]), .b13(b_v[2]),
    .b21(b_v[3]), .b22(b_v[4]), .b23(b_v[5]),
    .b31(b_v[6]), .b32(b_v[7]), .b33(b_v[8]),
    .c11(c11), .c12(c12), .c21(c21), .c22(c22),
    .done(done), .busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_c(input string tag, input int e11, input int e12, input int e21, input int e22);
    chk({tag, "_c11"}, {24'd0, c11}, e11);
    chk({tag, "_c12"}, {24'd0, c12}, e12);
    chk({tag, "_c21"}, {24'd0, c21}, e21);
    chk({tag, "_c22"}, {24'd0, c22}, e22);
  endtask

  task automatic set_all(input int av, input int bv);
    for (int n = 0; n < 16; n++) a_v[n] = av[7:0];
    for (int n = 0; n < 9; n++)  b_v[n] = bv[7:0];
  endtask

  // a_ij = 10*i + j, filter picks only the centre tap.
  task automatic set_ident();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) a_v[i*4+j] = 8'(10*(i+1) + (j+1));
    for (int n = 0; n < 9; n++) b_v[n] = 8'd0;
    b_v[4] = 8'd1;
  endtask

  // Called right after the accepting edge; returns edges until done and busy-high samples.
  task automatic wait_done(output int n, output int busyc, output logic [7:0] c11_mid);
    n = 0;
    busyc = busy ? 1 : 0;
    c11_mid = c11;
    while (!done && n < 100) begin
      tick();
      n++;
      if (busy) busyc++;
      if (n == 35) c11_mid = c11;
    end
  endtask

  task automatic leave_done(input string tag);
    tick();
    chk({tag, "_done_clr"}, {31'd0, done}, 0);
    chk({tag, "_busy_clr"}, {31'd0, busy}, 0);
  endtask

  task automatic run_op(input string tag, output int n, output int busyc);
    logic [7:0] mid;
    active_store = 1'b1;
    tick();
    active_store = 1'b0;
    wait_done(n, busyc, mid);
    chk({tag, "_latency"}, n, 36);
  endtask

  initial begin
    int n, busyc, dones;
    logic [7:0] mid;

    // Reset holds priority over a pending start.
    reset = 1'b1;
    active_store = 1'b1;
    set_ident();
    tick();
    tick();
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk_c("rst", 0, 0, 0, 0);

    // Start sampled at the first edge with reset low: identity filter.
    reset = 1'b0;
    tick();
    active_store = 1'b0;
    chk("ident_busy_start", {31'd0, busy}, 1);
    wait_done(n, busyc, mid);
    chk("ident_latency", n, 36);
    chk_c("ident", 22, 23, 32, 33);
    leave_done("ident");

    // All ones: every window sums to 9; busy spans 37 cycles.
    set_all(1, 1);
    run_op("ones", n, busyc);
    chk("ones_busy_cycles", busyc, 37);
    chk_c("ones", 9, 9, 9, 9);
    leave_done("ones");

    // Saturation at full scale.
    set_all(255, 255);
    run_op("full", n, busyc);
    chk_c("full", 255, 255, 255, 255);
    leave_done("full");

    // Single tap: 200*2 saturates, 100*2 does not.
    set_all(0, 0);
    b_v[0] = 8'd2;
    a_v[0] = 8'd200;
    a_v[1] = 8'd7;
    run_op("sat400", n, busyc);
    chk_c("sat400", 255, 14, 0, 0);
    leave_done("sat400");
    a_v[0] = 8'd100;
    run_op("sat200", n, busyc);
    chk_c("sat200", 200, 14, 0, 0);
    leave_done("sat200");

    // Inputs change and a stray start arrives mid-run: latched operands win.
    set_ident();
    active_store = 1'b1;
    tick();
    active_store = 1'b0;
    n = 0;
    while (!done && n < 100) begin
      tick();
      n++;
      if (n == 10) begin
        set_all(1, 1);
        active_store = 1'b1;
      end else begin
        active_store = 1'b0;
      end
    end
    chk("iso_latency", n, 36);
    chk_c("iso", 22, 23, 32, 33);
    leave_done("iso");
    dones = 0;
    for (int t = 0; t < 40; t++) begin
      tick();
      if (done || busy) dones++;
    end
    chk("iso_no_queue", dones, 0);
    run_op("iso_next", n, busyc);
    chk_c("iso_next", 9, 9, 9, 9);
    leave_done("iso_next");

    // Reset 20 cycles into CALC aborts with no done.
    set_ident();
    active_store = 1'b1;
    tick();
    active_store = 1'b0;
    for (int t = 0; t < 20; t++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_busy", {31'd0, busy}, 0);
    chk_c("abort", 0, 0, 0, 0);
    dones = 0;
    for (int t = 0; t < 40; t++) begin
      if (done) dones++;
      tick();
    end
    chk("abort_no_done", dones, 0);
    run_op("after_abort", n, busyc);
    chk_c("after_abort", 22, 23, 32, 33);

    // Back-to-back: start in the IDLE cycle right after done; c holds until the next done.
    tick();
    set_all(2, 1);
    active_store = 1'b1;
    tick();
    active_store = 1'b0;
    chk("b2b_accept", {31'd0, busy}, 1);
    wait_done(n, busyc, mid);
    chk("b2b_latency", n, 36);
    chk("b2b_hold_c11", {24'd0, mid}, 22);
    chk_c("b2b", 18, 18, 18, 18);
    leave_done("b2b");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
